// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-return writebacks onto one register-file write port,
// and sweeps every register with zero on request.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [$clog2(NREG)-1:0]   a_dest,
    input  logic [DATA_W-1:0]         a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [$clog2(NREG)-1:0]   b_dest,
    input  logic [DATA_W-1:0]         b_data,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic                      wr_en,
    output logic [$clog2(NREG)-1:0]   wr_dest,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      last_grant
);

    localparam int unsigned DEST_W = $clog2(NREG);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DEST_W-1:0]   cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [DEST_W-1:0]   wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                clr_busy_q, clr_busy_d;
    logic                last_grant_q, last_grant_d;
    logic                arb_open;
    logic                a_win;
    logic                b_win;

    // Ready is a pure function of state, valids and last grant; dest/data never gate it.
    always_comb begin
        arb_open = rst && (state_q == ST_ARB) && !clr_start;
        a_win    = a_valid && (!b_valid || last_grant_q);
        b_win    = b_valid && (!a_valid || !last_grant_q);
        a_ready  = arb_open && a_win;
        b_ready  = arb_open && b_win;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_dest_d    = wr_dest_q;
        wr_data_d    = wr_data_q;
        clr_busy_d   = 1'b0;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_ARB: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    wr_en_d    = 1'b1;
                    wr_dest_d  = '0;
                    wr_data_d  = '0;
                    clr_busy_d = 1'b1;
                end else if (a_ready) begin
                    wr_en_d      = 1'b1;
                    wr_dest_d    = a_dest;
                    wr_data_d    = a_data;
                    last_grant_d = 1'b0;
                end else if (b_ready) begin
                    wr_en_d      = 1'b1;
                    wr_dest_d    = b_dest;
                    wr_data_d    = b_data;
                    last_grant_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                // cnt_q is the index currently on the bus; the last one hands back to ARB.
                if (cnt_q == DEST_W'(NREG - 1)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + DEST_W'(1);
                    wr_en_d    = 1'b1;
                    wr_dest_d  = cnt_q + DEST_W'(1);
                    wr_data_d  = '0;
                    clr_busy_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_ARB;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_dest_q    <= '0;
            wr_data_q    <= '0;
            clr_busy_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_dest_q    <= wr_dest_d;
            wr_data_q    <= wr_data_d;
            clr_busy_q   <= clr_busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_dest    = wr_dest_q;
    assign wr_data    = wr_data_q;
    assign clr_busy   = clr_busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a cycle-level reference
// model of the arbitration and clear-sweep rules, with a mirrored register file.
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [3:0]    a_dest, b_dest, wr_dest;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          clr_start, clr_busy, wr_en, last_grant;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DW), .NREG(NR)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
        .last_grant(last_grant)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    int w0;

    // Requester-side pending writes, held until the model says they were accepted.
    logic          pa, pb;
    logic [3:0]    pa_d, pb_d;
    logic [DW-1:0] pa_x, pb_x;

    // Reference model: m_idx < 0 means arbitrating, otherwise the clear index on the bus.
    int            m_idx;
    logic          m_lg;
    logic          exp_en, exp_busy;
    logic [3:0]    exp_dest;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] rf_mod [NR];
    logic [DW-1:0] rf_dut [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic cs);
        logic m_ar, m_br;
        @(negedge clk);
        rst = r; clr_start = cs;
        a_valid = pa; a_dest = pa_d; a_data = pa_x;
        b_valid = pb; b_dest = pb_d; b_data = pb_x;
        #1;
        m_ar = r && (m_idx < 0) && !cs && pa && (!pb || m_lg);
        m_br = r && (m_idx < 0) && !cs && pb && (!pa || !m_lg);
        chk("a_ready", 32'(a_ready), 32'(m_ar));
        chk("b_ready", 32'(b_ready), 32'(m_br));
        chk("wr_en", 32'(wr_en), 32'(exp_en));
        chk("clr_busy", 32'(clr_busy), 32'(exp_busy));
        chk("last_grant", 32'(last_grant), 32'(m_lg));
        if (exp_en) begin
            chk("wr_dest", 32'(wr_dest), 32'(exp_dest));
            chk("wr_data", 32'(wr_data), 32'(exp_data));
        end
        if (wr_en === 1'b1) begin
            rf_dut[wr_dest] = wr_data;
            n_wr++;
        end
        if (!r) begin
            exp_en = 1'b0; exp_busy = 1'b0; m_lg = 1'b1; m_idx = -1;
        end else if (m_idx >= 0) begin
            if (m_idx == int'(NR) - 1) begin
                m_idx = -1; exp_en = 1'b0; exp_busy = 1'b0;
            end else begin
                m_idx++;
                exp_en = 1'b1; exp_busy = 1'b1;
                exp_dest = 4'(m_idx); exp_data = '0;
            end
        end else if (cs) begin
            m_idx = 0; exp_en = 1'b1; exp_busy = 1'b1;
            exp_dest = 4'd0; exp_data = '0;
        end else if (m_ar) begin
            exp_en = 1'b1; exp_busy = 1'b0; exp_dest = pa_d; exp_data = pa_x; m_lg = 1'b0;
        end else if (m_br) begin
            exp_en = 1'b1; exp_busy = 1'b0; exp_dest = pb_d; exp_data = pb_x; m_lg = 1'b1;
        end else begin
            exp_en = 1'b0; exp_busy = 1'b0;
        end
        if (exp_en) rf_mod[exp_dest] = exp_data;
        if (m_ar) pa = 1'b0;
        if (m_br) pb = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr_start = 1'b0;
        a_valid = 1'b0; a_dest = '0; a_data = '0;
        b_valid = 1'b0; b_dest = '0; b_data = '0;
        pa = 1'b0; pb = 1'b0; pa_d = '0; pb_d = '0; pa_x = '0; pb_x = '0;
        m_idx = -1; m_lg = 1'b1; exp_en = 1'b0; exp_busy = 1'b0;
        exp_dest = '0; exp_data = '0;
        for (int i = 0; i < int'(NR); i++) begin
            rf_mod[i] = 16'hC0DE; rf_dut[i] = 16'hC0DE;
        end
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_wr_dest", 32'(wr_dest), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);

        // Both requesters held: A first, then alternating
        for (int i = 0; i < 6; i++) begin
            pa = 1'b1; pa_d = 4'd3; pa_x = 16'h1111;
            pb = 1'b1; pb_d = 4'd5; pb_x = 16'h2222;
            step(1'b1, 1'b0);
            if (i == 0) chk("tie_first_a_ready", 32'(a_ready), 32'd1);
            if (i == 1) chk("tie_first_write", 32'(wr_data), 32'h1111);
            if (i == 2) chk("tie_second_write", 32'(wr_dest), 32'd5);
        end
        pa = 1'b0; pb = 1'b0;
        step(1'b1, 1'b0);

        // Single B write to the top register
        pb = 1'b1; pb_d = 4'd15; pb_x = 16'hFFFF;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("b_only_dest", 32'(wr_dest), 32'd15);
        chk("b_only_data", 32'(wr_data), 32'hFFFF);
        chk("b_only_grant", 32'(last_grant), 32'd1);
        step(1'b1, 1'b0);
        chk("b_only_no_repeat", 32'(wr_en), 32'd0);

        // Clear has priority over a concurrent A request
        pa = 1'b1; pa_d = 4'd9; pa_x = 16'h1234;
        step(1'b1, 1'b1);
        chk("clr_blocks_a", 32'(a_ready), 32'd0);
        w0 = n_wr;
        repeat (16) step(1'b1, 1'b0);
        chk("clr_write_count", 32'(n_wr - w0), 32'd16);
        step(1'b1, 1'b0);
        chk("post_clr_a_ready", 32'(a_ready), 32'd1);
        step(1'b1, 1'b0);
        chk("post_clr_a_write", 32'(wr_dest), 32'd9);

        // Reset aborts a sweep in its sixth cycle
        for (int i = 0; i < int'(NR); i++) begin
            rf_mod[i] = 16'h5A5A; rf_dut[i] = 16'h5A5A;
        end
        step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("abort_at_dest5", 32'(wr_dest), 32'd5);
        step(1'b1, 1'b0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(clr_busy), 32'd0);
        repeat (3) step(1'b1, 1'b0);
        for (int i = 6; i < int'(NR); i++) chk("abort_untouched", 32'(rf_dut[i]), 32'h5A5A);

        // Re-pulsed clear is ignored
        w0 = n_wr;
        step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        chk("repulse_write_count", 32'(n_wr - w0), 32'd16);

        // Same-destination tie with last_grant=0: B first, A last
        pa = 1'b1; pa_d = 4'd0; pa_x = 16'h0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        pa = 1'b1; pa_d = 4'd7; pa_x = 16'hAAAA;
        pb = 1'b1; pb_d = 4'd7; pb_x = 16'hBBBB;
        for (int i = 0; i < 8 && (pa || pb); i++) step(1'b1, 1'b0);
        chk("tie_drained", 32'(pa | pb), 32'd0);
        repeat (2) step(1'b1, 1'b0);
        chk("tie_final_r7", 32'(rf_dut[7]), 32'hAAAA);

        // Randomized traffic with occasional clears and resets
        for (int c = 0; c < 3000; c++) begin
            if (!pa && ($urandom_range(2) == 0)) begin
                pa = 1'b1; pa_d = 4'($urandom); pa_x = 16'($urandom);
            end
            if (!pb && ($urandom_range(2) == 0)) begin
                pb = 1'b1; pb_d = 4'($urandom); pb_x = 16'($urandom);
            end
            step(($urandom_range(199) != 0), ($urandom_range(39) == 0));
        end
        pa = 1'b0; pb = 1'b0;
        repeat (20) step(1'b1, 1'b0);
        for (int i = 0; i < int'(NR); i++) chk("rf_final", 32'(rf_dut[i]), 32'(rf_mod[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
